cv_pe_tile_seq: RTL and testbench

CV_PE_TILE_SEQ -- requirements
Module: cv_pe_tile_seq

---
 rtl/cv_pe_tile_seq.sv | 183 ++++++++++++++++++
 tb/tb_cv_pe_tile_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_pe_tile_seq.sv
`default_nettype none
// ============================================================================
// Module      : cv_pe_tile_seq
// Description : Per-PE tile sequencer. Addressed tile configurations are
//               queued in a small FIFO; on start, each queued tile is walked
//               through load-weight / load-input / store-output commands to
//               the compute core, waiting for core_idle between commands.
//               Optional macro CV_PE_WEIGHT_REUSE_EN skips load_weight when
//               the next tile shares Iext, Oext, Iori and Oori with the one
//               just finished.
// Revision    : 1.0 - initial release
// ============================================================================
module cv_pe_tile_seq #(
  parameter int PEID  = 0,
  parameter int ID_W  = 8,
  parameter int DIM_W = 13,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ID_W-1:0]          id,
  input  logic                     broadcast,
  input  logic                     cfg,
  input  logic [8*DIM_W-1:0]       cfg_tile,
  input  logic                     start,
  input  logic                     core_idle,
  output logic                     load_weight,
  output logic                     load_input,
  output logic                     store_output,
  output logic [8*DIM_W-1:0]       tile,
  output logic                     cfg_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int                c_ptr_w  = $clog2(DEPTH);
  localparam int                c_tile_w = 8*DIM_W;
  localparam logic [c_ptr_w:0]  c_depth  = (c_ptr_w+1)'(DEPTH);
  localparam logic [c_ptr_w:0]  c_one    = (c_ptr_w+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LW   = 3'd1,
    S_WW   = 3'd2,
    S_LI   = 3'd3,
    S_WI   = 3'd4,
    S_ST   = 3'd5,
    S_WS   = 3'd6,
    S_POP  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [c_tile_w-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w:0]      r_count;
  logic                  r_overflow;
  logic                  r_done;
  logic                  r_wait_first;

  logic                  w_addressed;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_more;
  logic                  w_reuse;
  logic                  w_done_set;
  logic                  w_start_ok;
  logic [c_tile_w-1:0]   w_head;

  assign w_addressed = (id == ID_W'(PEID)) || broadcast;
  assign w_push      = w_addressed && cfg && (r_count != c_depth);
  assign w_drop      = w_addressed && cfg && (r_count == c_depth);
  assign w_pop       = (r_state == S_POP) && (r_count != '0);
  // A tile remains after this pop if more were queued or one lands this cycle
  assign w_more      = (r_count > c_one) || w_push;
  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_head      = r_mem[r_rd_ptr];

`ifdef CV_PE_WEIGHT_REUSE_EN
  logic [c_tile_w-1:0]   w_next;
  // Next head is the following stored entry, or the tile being pushed now
  assign w_next  = (r_count > c_one) ? r_mem[r_rd_ptr + c_ptr_w'(1)] : cfg_tile;
  // Weights depend only on Iext, Oext (fields 0,1) and Iori, Oori (fields 4,5)
  assign w_reuse = w_more &&
                   (w_next[2*DIM_W-1:0]       == w_head[2*DIM_W-1:0]) &&
                   (w_next[6*DIM_W-1:4*DIM_W] == w_head[6*DIM_W-1:4*DIM_W]);
`else
  assign w_reuse = 1'b0;
`endif

  assign tile      = (r_count == '0) ? '0 : w_head;
  assign cfg_ready = (r_count != c_depth);
  assign count     = r_count;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign overflow  = r_overflow;

  // Storage holds no reset: emptiness is tracked by count and pointers alone
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cfg_tile;
  end

  // Queue pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      if (w_drop)          r_overflow <= 1'b1;
      else if (w_start_ok) r_overflow <= 1'b0;
    end
  end

  // State register, done pulse and first-wait-cycle marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_done       <= w_done_set;
      r_wait_first <= (r_state == S_LW) || (r_state == S_LI) || (r_state == S_ST);
    end
  end

  // Next-state and command pulse decode
  always_comb begin
    w_state_nxt  = r_state;
    load_weight  = 1'b0;
    load_input   = 1'b0;
    store_output = 1'b0;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (r_count != '0) w_state_nxt = S_LW;
          else               w_done_set  = 1'b1;
        end
      end
      S_LW: begin
        load_weight = 1'b1;
        w_state_nxt = S_WW;
      end
      S_WW: if (!r_wait_first && core_idle) w_state_nxt = S_LI;
      S_LI: begin
        load_input  = 1'b1;
        w_state_nxt = S_WI;
      end
      S_WI: if (!r_wait_first && core_idle) w_state_nxt = S_ST;
      S_ST: begin
        store_output = 1'b1;
        w_state_nxt  = S_WS;
      end
      S_WS: if (!r_wait_first && core_idle) w_state_nxt = S_POP;
      S_POP: begin
        if (w_more) begin
          w_state_nxt = w_reuse ? S_LI : S_LW;
        end else begin
          w_done_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cv_pe_tile_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv_pe_tile_seq
// Description : Directed bench for cv_pe_tile_seq with a queue/timeline
//               reference model and a per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv_pe_tile_seq;

  localparam int PEID  = 0;
  localparam int ID_W  = 8;
  localparam int DIM_W = 13;
  localparam int DEPTH = 4;
  localparam int TW    = 8*DIM_W;
  localparam int NCYC  = 1024;
  localparam int C_LW  = 1;
  localparam int C_LI  = 2;
  localparam int C_ST  = 3;
`ifdef CV_PE_WEIGHT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [ID_W-1:0]       id;
  logic                  broadcast, cfg, start, core_idle;
  logic [TW-1:0]         cfg_tile;
  logic                  load_weight, load_input, store_output;
  logic [TW-1:0]         tile;
  logic                  cfg_ready, busy, done, overflow;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  cv_pe_tile_seq #(.PEID(PEID), .ID_W(ID_W), .DIM_W(DIM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .broadcast(broadcast), .cfg(cfg),
    .cfg_tile(cfg_tile), .start(start), .core_idle(core_idle),
    .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
    .tile(tile), .cfg_ready(cfg_ready), .count(count), .busy(busy),
    .done(done), .overflow(overflow)
  );

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model: queue contents, sticky flag and an expected timeline
  logic [TW-1:0] mq[$];
  bit            movf;
  int            exp_cmd  [NCYC];
  bit            exp_done [NCYC];
  bit            exp_pop  [NCYC];
  bit            exp_busy [NCYC];

  int  lag        = 0;
  int  idle_cnt   = 100;
  bit  prev_pulse = 1'b0;
  int  log_q[$];
  int  done_seen  = 0;
  int  s_cyc;
  int  exp_q[$];
  bit  m_addr;
  int  m_sz;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [TW-1:0] mk(input int wo, ho, oo, io, we, he, oe, ie);
    return {DIM_W'(wo), DIM_W'(ho), DIM_W'(oo), DIM_W'(io),
            DIM_W'(we), DIM_W'(he), DIM_W'(oe), DIM_W'(ie)};
  endfunction

  function automatic int fld(input logic [TW-1:0] t, input int k);
    return int'(t[k*DIM_W +: DIM_W]);
  endfunction

  // Weights are shared when Iext, Oext, Iori and Oori all agree
  function automatic bit same_weights(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return fld(a,0) == fld(b,0) && fld(a,1) == fld(b,1) &&
           fld(a,4) == fld(b,4) && fld(a,5) == fld(b,5);
  endfunction

  task automatic model_clear();
    mq.delete();
    movf = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      exp_cmd[i] = 0; exp_done[i] = 1'b0; exp_pop[i] = 1'b0; exp_busy[i] = 1'b0;
    end
  endtask

  // Timeline for a start sampled at the end of cycle s: each command is
  // followed by a wait of max(2,lag) cycles, each tile ends with a pop cycle.
  task automatic schedule(input int s);
    int p, b, li;
    p = ((lag > 2) ? lag : 2) + 1;
    b = s + 1;
    for (int k = 0; k < mq.size(); k++) begin
      if (REUSE && k > 0 && same_weights(mq[k-1], mq[k])) begin
        li = b;
      end else begin
        if (b < NCYC) exp_cmd[b] = C_LW;
        li = b + p;
      end
      if (li < NCYC)       exp_cmd[li]       = C_LI;
      if (li + p < NCYC)   exp_cmd[li + p]   = C_ST;
      if (li + 2*p < NCYC) exp_pop[li + 2*p] = 1'b1;
      for (int c = b; c <= li + 2*p && c < NCYC; c++) exp_busy[c] = 1'b1;
      b = li + 2*p + 1;
    end
    if (b < NCYC) exp_done[b] = 1'b1;
  endtask

  // Model advance at every rising edge, using the inputs held over the cycle
  always @(posedge clk) begin
    if (rst_n) begin
      m_addr = (id == ID_W'(PEID)) || broadcast;
      m_sz   = mq.size();
      if (start && !exp_busy[cyc]) begin
        movf = 1'b0;
        schedule(cyc);
      end
      if (m_addr && cfg) begin
        if (m_sz < DEPTH) mq.push_back(cfg_tile);
        else              movf = 1'b1;
      end
      if (exp_pop[cyc] && mq.size() > 0) void'(mq.pop_front());
    end
    cyc++;
  end

  // Core model: idle drops right after a command and returns 'lag' cycles later
  always @(posedge clk) begin
    if (prev_pulse) idle_cnt = 1;
    else if (idle_cnt < 100) idle_cnt++;
    #1 core_idle = (idle_cnt >= lag);
  end

  // Mid-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("count",     count, mq.size());
    check("cfg_ready", cfg_ready, mq.size() < DEPTH);
    check("tile",      tile, (mq.size() == 0) ? '0 : mq[0]);
    check("overflow",  overflow, movf);
    check("busy",      busy, exp_busy[cyc]);
    check("done",      done, exp_done[cyc]);
    check("load_weight",  load_weight,  exp_cmd[cyc] == C_LW);
    check("load_input",   load_input,   exp_cmd[cyc] == C_LI);
    check("store_output", store_output, exp_cmd[cyc] == C_ST);
    check("cmd_onehot", (int'(load_weight) + int'(load_input) + int'(store_output)) <= 1, 1'b1);
    if (load_weight)  log_q.push_back(C_LW);
    if (load_input)   log_q.push_back(C_LI);
    if (store_output) log_q.push_back(C_ST);
    if (done) done_seen++;
    prev_pulse = load_weight || load_input || store_output;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 300 && done_seen == 0; i++) tick();
    if (done_seen == 0) begin
      nvec++; nfail++;
      $display("FAIL %s: got no done expected done within 300 cycles", name);
    end
    tick();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_%0d", name, i), (i < log_q.size()) ? log_q[i] : 0, exp_q[i]);
  endtask

  task automatic push(input logic [TW-1:0] t);
    cfg = 1'b1; cfg_tile = t;
    tick();
    cfg = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id = '0; broadcast = 1'b0; cfg = 1'b0; start = 1'b0;
    cfg_tile = '0; core_idle = 1'b1;
    model_clear();
    #2;
    check("rst_count", count, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_tile",  tile, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Addressing: foreign id ignored, broadcast accepted
    id = ID_W'(PEID + 1);
    push(mk(1,1,1,1,1,1,1,3));
    tick();
    check("foreign_id_count", count, 0);
    broadcast = 1'b1;
    push(mk(2,2,2,2,2,2,2,5));
    broadcast = 1'b0;
    check("bcast_count", count, 1);
    check("bcast_tile",  tile, mk(2,2,2,2,2,2,2,5));
    done_seen = 0;
    do_start();
    wait_done("drain1");

    // Two tiles, core returns idle two cycles after each command
    lag = 2;
    id = ID_W'(PEID);
    push(mk(1,2,3,4,5,6,7,8));
    push(mk(9,9,9,9,9,9,9,9));
    check("two_count", count, 2);
    log_q.delete(); done_seen = 0;
    do_start();
    check("pin_lw0",  exp_cmd[s_cyc+1], C_LW);
    check("pin_li0",  exp_cmd[s_cyc+4], C_LI);
    check("pin_st0",  exp_cmd[s_cyc+7], C_ST);
    check("pin_pop0", exp_pop[s_cyc+10], 1);
    check("pin_lw1",  exp_cmd[s_cyc+11], C_LW);
    check("pin_done", exp_done[s_cyc+21], 1);
    wait_done("two_tiles");
    exp_q = '{C_LW, C_LI, C_ST, C_LW, C_LI, C_ST};
    check_log("two_order");
    check("two_done_once", done_seen, 1);
    check("two_count_end", count, 0);

    // Start with empty queue
    log_q.delete(); done_seen = 0;
    do_start();
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    tick();
    check("empty_done_off", done, 0);
    check("empty_no_cmd", log_q.size(), 0);

    // Overflow: fifth push dropped, start clears flag; core always idle
    lag = 0;
    broadcast = 1'b1; id = ID_W'(PEID + 7);
    for (int i = 0; i < 5; i++) begin
      push(mk(i, 0, 2*i, 3, 1, 1, i, 10 + i));
      if (i == 3) begin
        check("full_ready", cfg_ready, 0);
        check("full_count", count, 4);
      end
    end
    broadcast = 1'b0;
    check("ovf_set",   overflow, 1);
    check("ovf_count", count, 4);
    log_q.delete(); done_seen = 0;
    do_start();
    check("ovf_clear", overflow, 0);
    wait_done("four_tiles");
    check("four_cmds", log_q.size(), 12);

    // Reset asserted while waiting on the input load
    lag = 3;
    id = ID_W'(PEID);
    push(mk(1,1,1,1,1,1,1,1));
    push(mk(2,2,2,2,2,2,2,2));
    log_q.delete();
    do_start();
    for (int i = 0; i < 50 && log_q.size() < 2; i++) tick();
    check("reach_li", log_q.size(), 2);
    tick();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_lw",    load_weight, 0);
    check("mid_rst_li",    load_input, 0);
    check("mid_rst_st",    store_output, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_tile",  tile, 0);
    check("mid_rst_ready", cfg_ready, 1);
    log_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("post_rst_quiet", log_q.size(), 0);

    // Tiles sharing weight fields
    lag = 2;
    push(mk(1,1,3,4,1,1,7,8));
    push(mk(2,2,3,4,2,2,7,8));
    log_q.delete(); done_seen = 0;
    do_start();
    wait_done("reuse_pair");
    if (REUSE) exp_q = '{C_LW, C_LI, C_ST, C_LI, C_ST};
    else       exp_q = '{C_LW, C_LI, C_ST, C_LW, C_LI, C_ST};
    check_log("reuse_order");
    check("reuse_done_once", done_seen, 1);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
